// File: rtl/dll_disc_divider_pkg.sv
// Shared widths, timing constants, FSM encodings and the encoder-position
// helper for the DLL discriminator divider.
package dll_disc_divider_pkg;

  localparam int NUM_W       = 20;  // signed numerator (early - late)
  localparam int DEN_W       = 19;  // unsigned denominator (early + late)
  localparam int Q_W         = 10;  // quotient magnitude bits (Q0.10)
  localparam int RES_W       = 11;  // signed result
  localparam int DS_W        = 12;  // normalised operand width
  localparam int POS_W       = 5;   // priority encoder output width
  localparam int SHIFT_W     = 4;   // normalisation shift, 0..11
  localparam int DIV_ITERS   = 10;  // one quotient bit per iteration
  localparam int ENC_LAT     = 2;   // priority encoder latency in cycles
  localparam int ENC_MIN_POS = 7;
  localparam int ENC_MAX_POS = 18;
  localparam int WAIT_W      = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ENC_WAIT = 3'd1;
  localparam logic [2:0] ST_NORM     = 3'd2;
  localparam logic [2:0] ST_DIV      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Clamp the encoder position into the usable window and turn it into
  // the right-shift that brings den into 12 bits.
  function automatic logic [SHIFT_W-1:0] pos_to_shift(input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] clamped;
    if (pos < POS_W'(ENC_MIN_POS))
      clamped = POS_W'(ENC_MIN_POS);
    else if (pos > POS_W'(ENC_MAX_POS))
      clamped = POS_W'(ENC_MAX_POS);
    else
      clamped = pos;
    return SHIFT_W'(clamped - POS_W'(ENC_MIN_POS));
  endfunction

endpackage

// File: rtl/dll_disc_divider.sv
// DLL discriminator divider: result = num/den in Q0.10, using an external
// priority encoder position to normalise both operands to 12 bits, then a
// 10-cycle restoring divider. Fixed latency: done 14 cycles after start.
module dll_disc_divider
  import dll_disc_divider_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  input  logic [POS_W-1:0] enc_pos,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ENC_LAT - 1);
  localparam logic [3:0]        ITER_LAST = 4'(DIV_ITERS - 1);

  logic [2:0]         state_reg;
  logic [NUM_W-1:0]   num_reg;
  logic [DEN_W-1:0]   den_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic [DS_W-1:0]    den_s_reg;
  logic [DS_W-1:0]    rem_reg;
  // Only the low 9 quotient bits need storing; the 10th comes straight
  // from the final iteration into the result.
  logic [Q_W-2:0]     quo_reg;
  logic [3:0]         iter_cnt_reg;
  logic               neg_reg;
  logic               zero_reg;
  logic [RES_W-1:0]   result_reg;

  logic [NUM_W-1:0]   mag_full;
  logic [NUM_W-1:0]   mag_shifted;
  logic [DS_W-1:0]    den_s_c;
  logic [DS_W-1:0]    mag_s_c;
  logic [DS_W:0]      rem_dbl;
  logic [DS_W:0]      rem_sub;
  logic               q_bit;
  logic [DS_W-1:0]    rem_c;
  logic [Q_W-1:0]     quo_c;
  logic [RES_W-1:0]   res_c;

  // Normalisation: shift |num| and den by the same amount, then clamp the
  // magnitude so the quotient never exceeds one (mag==den yields 1023).
  always_comb begin
    mag_full    = num_reg[NUM_W-1] ? (~num_reg + 1'b1) : num_reg;
    mag_shifted = mag_full >> shift_reg;
    den_s_c     = DS_W'(den_reg >> shift_reg);
    if (mag_shifted > NUM_W'(den_s_c))
      mag_s_c = den_s_c;
    else
      mag_s_c = mag_shifted[DS_W-1:0];
  end

  // One restoring-division step; with rem <= den the all-ones quotient is
  // the natural ceiling, which doubles as saturation of 1024 to 1023.
  always_comb begin
    rem_dbl = {rem_reg, 1'b0};
    rem_sub = rem_dbl - {1'b0, den_s_reg};
    q_bit   = (rem_dbl >= {1'b0, den_s_reg});
    rem_c   = DS_W'(q_bit ? rem_sub : rem_dbl);
    quo_c   = {quo_reg, q_bit};
    res_c   = neg_reg ? (~{1'b0, quo_c} + 1'b1) : {1'b0, quo_c};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      num_reg      <= '0;
      den_reg      <= '0;
      wait_cnt_reg <= '0;
      shift_reg    <= '0;
      den_s_reg    <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      iter_cnt_reg <= '0;
      neg_reg      <= 1'b0;
      zero_reg     <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            num_reg      <= num;
            den_reg      <= den;
            wait_cnt_reg <= '0;
            state_reg    <= ST_ENC_WAIT;
          end
        end
        ST_ENC_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            shift_reg <= pos_to_shift(enc_pos);
            state_reg <= ST_NORM;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_NORM: begin
          den_s_reg    <= den_s_c;
          rem_reg      <= mag_s_c;
          quo_reg      <= '0;
          iter_cnt_reg <= '0;
          neg_reg      <= num_reg[NUM_W-1];
          zero_reg     <= (den_s_c == '0);
          state_reg    <= ST_DIV;
        end
        ST_DIV: begin
          rem_reg      <= rem_c;
          quo_reg      <= quo_c[Q_W-2:0];
          iter_cnt_reg <= iter_cnt_reg + 1'b1;
          if (iter_cnt_reg == ITER_LAST) begin
            result_reg <= zero_reg ? '0 : res_c;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_dll_disc_divider.sv
// Directed scoreboard bench for dll_disc_divider.
module tb_dll_disc_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] num = '0;
  logic [18:0] den = '0;
  logic [4:0]  enc_pos = '0;
  logic        busy;
  logic        done;
  logic [10:0] result;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic signed [10:0] res;
    int                 at;
    string              name;
  } exp_t;

  exp_t sb_q[$];

  dll_disc_divider dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .num     (num),
    .den     (den),
    .enc_pos (enc_pos),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, int'($signed(result)), int'(e.res));
        check({e.name, "_done_cycle"}, cyc, e.at);
        $display("txn %s: result=%0d expected=%0d done_cycle=%0d", e.name,
                 $signed(result), e.res, cyc);
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    check({name, "_timeout"}, sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  // Called at a negedge: start is high for the current cycle k.
  task automatic run_op(input string name, input logic signed [19:0] n,
                        input logic [18:0] d, input logic [4:0] p,
                        input logic signed [10:0] exp_res, input bit poke);
    exp_t e;
    e.res  = exp_res;
    e.at   = cyc + 14;
    e.name = name;
    sb_q.push_back(e);
    start = 1'b1; num = n; den = d; enc_pos = 5'($urandom());
    @(negedge clk);                       // k+1
    start = 1'b0; num = 20'($urandom()); den = 19'($urandom());
    check({name, "_busy"}, int'(busy), 1);
    @(negedge clk);                       // k+2: encoder output valid
    enc_pos = p;
    @(negedge clk);                       // k+3
    enc_pos = 5'($urandom()); num = 20'($urandom()); den = 19'($urandom());
    @(negedge clk);                       // k+4
    @(negedge clk);                       // k+5
    if (poke) begin
      start = 1'b1; num = -20'sd300; den = 19'd1000; enc_pos = 5'd9;
    end
    @(negedge clk);                       // k+6
    start = 1'b0;
    wait_drain(name);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_held_result"}, int'($signed(result)), int'(exp_res));
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // start presented immediately so the first edge after release takes it
    run_op("half",      20'sd500,     19'd1000,   5'd9,  11'sd512,   1'b0);
    run_op("neg_sat",  -20'sd1000,    19'd1000,   5'd9, -11'sd1023,  1'b0);
    run_op("wide",      20'sd131072,  19'd262144, 5'd18, 11'sd512,   1'b0);
    run_op("den_zero",  20'sd37,      19'd0,      5'd7,  11'sd0,     1'b0);
    run_op("busy_poke", 20'sd300,     19'd1000,   5'd9,  11'sd307,   1'b1);
    run_op("neg_frac", -20'sd200,     19'd600,    5'd9, -11'sd341,   1'b0);
    run_op("clamp_lo",  20'sd3,       19'd10,     5'd3,  11'sd307,   1'b0);
    run_op("clamp_hi", -20'sd262144,  19'd524287, 5'd25, -11'sd514,  1'b0);
    run_op("mag_gt",    20'sd5000,    19'd1000,   5'd9,  11'sd1023,  1'b0);
    run_op("num_min",  -20'sd524288,  19'd524287, 5'd18, -11'sd1023, 1'b0);
    run_op("pre_abort", 20'sd500,     19'd1000,   5'd9,  11'sd512,   1'b0);

    // Abort mid-DIV: start at k, reset at k+8, no done may follow.
    start = 1'b1; num = 20'sd700; den = 19'd1000; enc_pos = 5'd0;
    @(negedge clk);                       // k+1
    start = 1'b0;
    @(negedge clk);                       // k+2
    enc_pos = 5'd9;
    repeat (6) @(negedge clk);            // k+8
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);           // past k+14; monitor flags any done
    check("abort_no_pending", sb_q.size(), 0);

    run_op("post_abort", 20'sd500, 19'd1000, 5'd9, 11'sd512, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
